// File: rtl/trbuf_arb_if.sv
// Transmit buffer arbiter bus: host port, TCL port, tx lock, RAM port and busy flag.
interface trbuf_arb_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  // Host register access port
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_adr;
  logic [DW-1:0] h_wdata;
  logic          h_ack;
  logic [DW-1:0] h_rdata;
  logic          h_err;
  // TCL fetch port
  logic          t_req;
  logic [AW-1:0] t_adr;
  logic          t_ack;
  logic [DW-1:0] t_rdata;
  // Write lock from the transmit control
  logic          tx_lock;
  // Single-port synchronous RAM
  logic [AW-1:0] ram_adr;
  logic          ram_we_b;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  // Sequencer status
  logic          busy;

  // Arbiter side
  modport slave (
    input  h_req, h_we, h_adr, h_wdata, t_req, t_adr, tx_lock, ram_rdata,
    output h_ack, h_rdata, h_err, t_ack, t_rdata, ram_adr, ram_we_b, ram_wdata, busy
  );

  // Requesters and RAM side
  modport master (
    output h_req, h_we, h_adr, h_wdata, t_req, t_adr, tx_lock, ram_rdata,
    input  h_ack, h_rdata, h_err, t_ack, t_rdata, ram_adr, ram_we_b, ram_wdata, busy
  );
endinterface

// File: rtl/trbuf_arb.sv
// Round-robin arbiter and 4-cycle access sequencer for the CAN transmit buffer RAM.
// Host writes are rejected (no RAM write, h_err pulsed with h_ack) while tx_lock is set at grant.
module trbuf_arb #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input logic         clk,
  input logic         reset_b,
  trbuf_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_CAP  = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_TCL  = 1'b1
  } owner_t;

  state_t        r_state;
  owner_t        r_owner;
  owner_t        r_last;
  logic          r_wr;
  logic          r_lock_hit;
  logic          r_h_ack;
  logic          r_h_err;
  logic [DW-1:0] r_h_rdata;
  logic          r_t_ack;
  logic [DW-1:0] r_t_rdata;
  logic [AW-1:0] r_ram_adr;
  logic          r_ram_we_b;
  logic [DW-1:0] r_ram_wdata;
  logic          r_busy;

  logic          w_grant_t;
  logic          w_grant_h;

  // TCL wins when alone or when the host was served last; host takes everything else.
  assign w_grant_t = bus.t_req & (~bus.h_req | (r_last == OWN_HOST));
  assign w_grant_h = bus.h_req & ~w_grant_t;

  assign bus.h_ack     = r_h_ack;
  assign bus.h_err     = r_h_err;
  assign bus.h_rdata   = r_h_rdata;
  assign bus.t_ack     = r_t_ack;
  assign bus.t_rdata   = r_t_rdata;
  assign bus.ram_adr   = r_ram_adr;
  assign bus.ram_we_b  = r_ram_we_b;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.busy      = r_busy;

  // Sequencer: grant in IDLE, drive RAM in ACC, capture read data in CAP, pulse ack in ACK.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_HOST;
      r_last      <= OWN_HOST;
      r_wr        <= 1'b0;
      r_lock_hit  <= 1'b0;
      r_h_ack     <= 1'b0;
      r_h_err     <= 1'b0;
      r_h_rdata   <= '0;
      r_t_ack     <= 1'b0;
      r_t_rdata   <= '0;
      r_ram_adr   <= '0;
      r_ram_we_b  <= 1'b1;
      r_ram_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_h_ack <= 1'b0;
      r_h_err <= 1'b0;
      r_t_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_t) begin
            r_state    <= S_ACC;
            r_busy     <= 1'b1;
            r_owner    <= OWN_TCL;
            r_last     <= OWN_TCL;
            r_ram_adr  <= bus.t_adr;
            r_wr       <= 1'b0;
            r_lock_hit <= 1'b0;
            r_ram_we_b <= 1'b1;
          end else if (w_grant_h) begin
            r_state     <= S_ACC;
            r_busy      <= 1'b1;
            r_owner     <= OWN_HOST;
            r_last      <= OWN_HOST;
            r_ram_adr   <= bus.h_adr;
            r_ram_wdata <= bus.h_wdata;
            r_wr        <= bus.h_we;
            r_lock_hit  <= bus.h_we & bus.tx_lock;
            // Write strobe is registered here so it is live for the whole ACC cycle
            r_ram_we_b  <= ~(bus.h_we & ~bus.tx_lock);
          end
        end
        S_ACC: begin
          r_state    <= S_CAP;
          r_ram_we_b <= 1'b1;
        end
        S_CAP: begin
          r_state <= S_ACK;
          if (r_owner == OWN_TCL) begin
            r_t_rdata <= bus.ram_rdata;
            r_t_ack   <= 1'b1;
          end else begin
            if (!r_wr) begin
              r_h_rdata <= bus.ram_rdata;
            end
            r_h_ack <= 1'b1;
            r_h_err <= r_lock_hit;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
